nlp_fetch_unit: RTL and testbench
=================================

NLP_FETCH_UNIT -- requirements
Module: nlp_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction/bus data width.
REQ-002 SHALL have parameter ADDR_W, default 16, word address width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two, >=2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL use one clock, i_clk; reset is asynchronous and active-high, port i_rst.
REQ-006 Ports (name direction width meaning):
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  async active-high reset.
- i_gnt  in  1  bus grant; core data access owns the bus when low.
- o_rd  out  1  fetch read request.
- o_address  out  ADDR_W  fetch word address.
- i_bus  in  DATA_W  read data; valid when i_ack=1.
- i_ack  in  1  memory acknowledge, completes the current request.
- i_redirect  in  1  flush and restart fetch (branch/jump).
- i_redirect_pc  in  ADDR_W  new fetch address.
- o_ir_valid  out  1  queue head valid.
- o_ir  out  DATA_W  queue head instruction word.
- o_ir_pc  out  ADDR_W  address of o_ir.
- i_ir_ready  in  1  consumer accepts head.

Function
REQ-007 SHALL implement FSM states IDLE, REQ, DRAIN.
REQ-008 IDLE->REQ when i_gnt=1, occupancy<DEPTH, i_redirect=0; o_rd=1, o_address=fetch_pc from the next cycle on.
REQ-009 In REQ, o_rd and o_address SHALL hold stable until i_ack=1, regardless of i_gnt.
REQ-010 On i_ack in REQ (no redirect): write {i_bus, fetch_pc} to queue, fetch_pc+=1 modulo 2^ADDR_W, go IDLE.
REQ-011 At most one request outstanding; no back-to-back o_rd without an IDLE cycle between.
REQ-012 Pop when o_ir_valid & i_ir_ready; o_ir/o_ir_pc are queue head, registered.
REQ-013 Push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-014 Queue pointers SHALL wrap modulo DEPTH; occupancy range 0..DEPTH.
REQ-015 i_redirect SHALL flush queue (occupancy 0, o_ir_valid=0 next cycle) and load fetch_pc=i_redirect_pc; any same-cycle pop is ignored.
REQ-016 Redirect in REQ without same-cycle i_ack -> DRAIN: keep o_rd/o_address until i_ack, discard data, then IDLE.
REQ-017 Redirect with same-cycle i_ack -> discard data, go IDLE.
REQ-018 Redirect in DRAIN -> update fetch_pc only, stay DRAIN.
REQ-019 Redirect in IDLE -> stay IDLE; new fetch may start next cycle.

Reset
REQ-020 On i_rst: state IDLE, fetch_pc=RESET_PC, occupancy 0, o_rd=0, o_ir_valid=0, o_address=RESET_PC, o_ir=0, o_ir_pc=0.
REQ-021 Reset mid-request SHALL drop o_rd immediately; a later stale i_ack in IDLE SHALL be ignored.

Configuration
REQ-022 Macro NLP_FETCH_BYPASS_EN defined: when occupancy=0 and i_ack in REQ, o_ir_valid=1, o_ir=i_bus, o_ir_pc=fetch_pc combinationally that cycle; if i_ir_ready=1 the word is not written to the queue.
REQ-023 Macro undefined: no bypass; fetched word visible on o_ir one cycle after i_ack (minimum latency o_rd->o_ir_valid = ack cycle +1).

Verification
REQ-024 Reset, i_gnt=1, i_ack one cycle after each o_rd, i_ir_ready=1 -> o_address 0,1,2,3; o_ir_pc 0,1,2,3 in order with matching data.
REQ-025 i_ir_ready=0, DEPTH=4 -> exactly 4 fetches (0..3), then o_rd stays 0; one pop -> fetch of address 4.
REQ-026 Redirect to 0x0100 while o_rd pending at 0x0005, i_ack 3 cycles later -> data at 0x0005 discarded, next o_address=0x0100, o_ir_pc=0x0100.
REQ-027 fetch_pc=0xFFFF, ack -> next o_address=0x0000.
REQ-028 i_gnt=0 in IDLE -> o_rd stays 0; i_gnt drop during REQ -> o_rd held until i_ack.
REQ-029 Empty queue, i_ack with i_ir_ready=1 -> o_ir_valid same cycle with NLP_FETCH_BYPASS_EN, next cycle without; occupancy stays 0 with bypass.

Source files
------------

// File: rtl/nlp_fetch_unit.sv
// nlp_fetch_unit: single-outstanding instruction fetcher feeding a DEPTH-entry
// prefetch queue, with redirect (flush + restart) and drain of an in-flight
// request whose data is no longer wanted.
// Optional build macro NLP_FETCH_BYPASS_EN: present an acknowledged word on
// o_ir in the same cycle when the queue is empty.
module nlp_fetch_unit #(
  parameter int unsigned        DATA_W   = 16,
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_gnt,
  output logic              o_rd,
  output logic [ADDR_W-1:0] o_address,
  input  logic [DATA_W-1:0] i_bus,
  input  logic              i_ack,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_ir_valid,
  output logic [DATA_W-1:0] o_ir,
  output logic [ADDR_W-1:0] o_ir_pc,
  input  logic              i_ir_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_start;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_mem_data [DEPTH];
  logic [ADDR_W-1:0]   r_mem_pc   [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_empty;
  logic                w_not_full;
  logic                w_ack_ok;
  logic                w_bypass;
  logic                w_push;
  logic                w_pop;

  assign w_empty    = (r_count == '0);
  assign w_not_full = (r_count < CNT_W'(DEPTH));
  // Accepted data: ack on a live request that is not being redirected away.
  assign w_ack_ok   = (r_state == REQ) && i_ack && !i_redirect;

`ifdef NLP_FETCH_BYPASS_EN
  assign w_bypass = w_ack_ok && w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word taken by the consumer the same cycle never enters the queue.
  assign w_push = w_ack_ok && !(w_bypass && i_ir_ready);
  assign w_pop  = !w_empty && i_ir_ready && !i_redirect;

  assign o_rd       = (r_state != IDLE);
  assign o_address  = r_addr;
  assign o_ir_valid = !w_empty || w_bypass;
  assign o_ir       = w_bypass ? i_bus  : r_mem_data[r_rptr];
  assign o_ir_pc    = w_bypass ? r_addr : r_mem_pc[r_rptr];

  // Fetch FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Fetch FSM next-state: issue when granted with room, hold until ack.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_gnt && w_not_full && !i_redirect) begin
          w_state_nxt = REQ;
          w_start     = 1'b1;
        end
      end
      REQ: begin
        if (i_ack)           w_state_nxt = IDLE;
        else if (i_redirect) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (i_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Fetch PC and the held request address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else begin
      if (i_redirect)    r_fetch_pc <= i_redirect_pc;
      else if (w_ack_ok) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      if (w_start)       r_addr     <= r_fetch_pc;
    end
  end

  // Prefetch queue: circular buffer, flushed by redirect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (i_redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wptr] <= i_bus;
        r_mem_pc[r_wptr]   <= r_addr;
        r_wptr             <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_nlp_fetch_unit.sv
// Self-checking bench for nlp_fetch_unit: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_nlp_fetch_unit;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 4;
`ifdef NLP_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_gnt = 1'b0;
  logic          o_rd;
  logic [AW-1:0] o_address;
  logic [DW-1:0] i_bus = '0;
  logic          i_ack = 1'b0;
  logic          i_redirect = 1'b0;
  logic [AW-1:0] i_redirect_pc = '0;
  logic          o_ir_valid;
  logic [DW-1:0] o_ir;
  logic [AW-1:0] o_ir_pc;
  logic          i_ir_ready = 1'b0;

  nlp_fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_gnt(i_gnt), .o_rd(o_rd), .o_address(o_address),
    .i_bus(i_bus), .i_ack(i_ack), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_ir_valid(o_ir_valid), .o_ir(o_ir), .o_ir_pc(o_ir_pc), .i_ir_ready(i_ir_ready)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of fetched words plus a note of the in-flight request.
  typedef struct { logic [DW-1:0] d; logic [AW-1:0] pc; } ent_t;
  ent_t          q[$];
  bit            m_out;    // a request is on the bus
  bit            m_disc;   // its data has been made stale by a redirect
  logic [AW-1:0] m_fpc;    // next address to fetch
  logic [AW-1:0] m_raddr;  // address of the last issued request

  task automatic model_reset();
    q.delete();
    m_out = 0; m_disc = 0; m_fpc = '0; m_raddr = '0;
  endtask

  // Called at posedge+1; asserts reset asynchronously, checks, releases next edge.
  task automatic do_reset();
    i_rst = 1'b1; i_gnt = 0; i_ack = 0; i_redirect = 0; i_ir_ready = 0;
    #1;
    chk("rst_rd", o_rd, 0);
    chk("rst_valid", o_ir_valid, 0);
    chk("rst_addr", o_address, 0);
    chk("rst_ir", o_ir, 0);
    chk("rst_ir_pc", o_ir_pc, 0);
    model_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  // One cycle: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic cyc(input bit g, input bit a, input bit r, input logic [AW-1:0] rp, input bit rdy);
    bit byp, e_valid, pop, acc, start;
    logic [DW-1:0] e_ir;
    logic [AW-1:0] e_pc;
    int occ;
    i_gnt = g; i_ack = a; i_redirect = r; i_redirect_pc = rp; i_ir_ready = rdy;
    i_bus = DW'($urandom);
    #4;
    occ = q.size();
    byp = BYP && occ == 0 && m_out && !m_disc && a && !r;
    e_valid = (occ != 0) || byp;
    e_ir = (occ != 0) ? q[0].d  : i_bus;
    e_pc = (occ != 0) ? q[0].pc : m_raddr;
    chk("rd", o_rd, m_out);
    chk("address", o_address, m_raddr);
    chk("ir_valid", o_ir_valid, e_valid);
    if (e_valid) begin
      chk("ir", o_ir, e_ir);
      chk("ir_pc", o_ir_pc, e_pc);
    end
    @(posedge i_clk);
    pop   = e_valid && rdy && !r;
    acc   = m_out && a && !m_disc && !r;
    start = !m_out && g && occ < DEPTH && !r;
    if (r) begin
      q.delete();
      m_fpc = rp;
    end else begin
      if (pop && occ != 0) void'(q.pop_front());
      if (acc) begin
        if (!(byp && rdy)) q.push_back('{i_bus, m_raddr});
        m_fpc = m_raddr + 1'b1;
      end
    end
    if (m_out && a) begin
      m_out = 0; m_disc = 0;
    end else if (m_out && r) begin
      m_disc = 1;
    end else if (start) begin
      m_out = 1; m_raddr = m_fpc;
    end
    #1;
  endtask

  typedef struct {
    bit g, a, rdy;
    logic [DW-1:0] bus;
    bit e_rd; logic [AW-1:0] e_addr; bit e_valid; logic [AW-1:0] e_pc;
  } vec_t;
  vec_t tbl[9];

  initial begin
    // Straight-line fetch with immediate ack and an always-ready consumer.
    tbl[0] = '{1, 0, 1, 16'h0000, 0, 16'h0, 0,    16'h0};
    tbl[1] = '{1, 1, 1, 16'hA000, 1, 16'h0, BYP,  16'h0};
    tbl[2] = '{1, 0, 1, 16'h0000, 0, 16'h0, !BYP, 16'h0};
    tbl[3] = '{1, 1, 1, 16'hA001, 1, 16'h1, BYP,  16'h1};
    tbl[4] = '{1, 0, 1, 16'h0000, 0, 16'h1, !BYP, 16'h1};
    tbl[5] = '{1, 1, 1, 16'hA002, 1, 16'h2, BYP,  16'h2};
    tbl[6] = '{1, 0, 1, 16'h0000, 0, 16'h2, !BYP, 16'h2};
    tbl[7] = '{1, 1, 1, 16'hA003, 1, 16'h3, BYP,  16'h3};
    tbl[8] = '{1, 0, 1, 16'h0000, 0, 16'h3, !BYP, 16'h3};

    model_reset();
    @(posedge i_clk); #1;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      i_gnt = tbl[i].g; i_ack = tbl[i].a; i_ir_ready = tbl[i].rdy;
      i_bus = tbl[i].bus; i_redirect = 0;
      #4;
      chk("tbl_rd", o_rd, tbl[i].e_rd);
      chk("tbl_addr", o_address, tbl[i].e_addr);
      chk("tbl_valid", o_ir_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk("tbl_pc", o_ir_pc, tbl[i].e_pc);
        chk("tbl_ir", o_ir, 16'hA000 + tbl[i].e_pc);
      end
      @(posedge i_clk); #1;
    end

    // Consumer stalled: exactly DEPTH fetches, then one pop frees a slot.
    do_reset();
    repeat (12) cyc(1, m_out, 0, '0, 0);
    chk("full_rd", o_rd, 0);
    chk("full_head_pc", o_ir_pc, 16'h0000);
    chk("full_valid", o_ir_valid, 1);
    cyc(1, 0, 0, '0, 1);
    cyc(1, 0, 0, '0, 0);
    chk("refill_rd", o_rd, 1);
    chk("refill_addr", o_address, 16'h0004);

    // Redirect while a request is pending: stale data dropped.
    do_reset();
    cyc(1, 0, 1, 16'h0005, 1);
    cyc(1, 0, 0, '0, 1);
    chk("pend_rd", o_rd, 1);
    chk("pend_addr", o_address, 16'h0005);
    cyc(1, 0, 1, 16'h0100, 1);
    cyc(1, 0, 0, '0, 1);
    cyc(1, 0, 0, '0, 1);
    chk("drain_rd", o_rd, 1);
    chk("drain_addr", o_address, 16'h0005);
    cyc(1, 1, 0, '0, 1);
    chk("drain_done_rd", o_rd, 0);
    chk("drain_empty", o_ir_valid, 0);
    cyc(1, 0, 0, '0, 1);
    chk("redir_addr", o_address, 16'h0100);
    cyc(1, 1, 0, '0, 0);
    chk("redir_valid", o_ir_valid, 1);
    chk("redir_pc", o_ir_pc, 16'h0100);
    cyc(1, 0, 0, '0, 1);

    // Address wrap at the top of the space.
    do_reset();
    cyc(1, 0, 1, 16'hFFFF, 1);
    cyc(1, 0, 0, '0, 1);
    chk("wrap_addr0", o_address, 16'hFFFF);
    cyc(1, 1, 0, '0, 1);
    cyc(1, 0, 0, '0, 1);
    chk("wrap_rd", o_rd, 1);
    chk("wrap_addr1", o_address, 16'h0000);

    // Grant low blocks issue; grant drop mid-request does not.
    do_reset();
    repeat (3) cyc(0, 0, 0, '0, 1);
    chk("nognt_rd", o_rd, 0);
    cyc(1, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);
    chk("gntdrop_rd", o_rd, 1);
    cyc(0, 1, 0, '0, 1);
    chk("gntdrop_ack_rd", o_rd, 0);

    // Reset mid-request, then a stale ack must be ignored.
    do_reset();
    cyc(1, 0, 0, '0, 1);
    chk("midrst_pre", o_rd, 1);
    i_rst = 1'b1;
    #1;
    chk("midrst_rd", o_rd, 0);
    model_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    cyc(0, 1, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);
    chk("stale_valid", o_ir_valid, 0);
    chk("stale_rd", o_rd, 0);

    // Randomized traffic in phases of varying consumer readiness.
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 600; n++) begin
        bit g, a, r, rdy;
        logic [AW-1:0] rp;
        g   = ($urandom_range(0, 3) != 0);
        a   = m_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
        r   = ($urandom_range(0, 24) == 0);
        rp  = ($urandom_range(0, 7) == 0) ? 16'hFFFE : AW'($urandom);
        rdy = ($urandom_range(0, 3) < ph + 1);
        cyc(g, a, r, rp, rdy);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
